mem_seq: RTL and testbench
==========================

MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 Parameters: MAX_ROW, default 540, image rows; MAX_COL, default 540, image columns; ADDR_W, default 19, BRAM address width; DATA_W, default 8, pixel width.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high; clears all state immediately on assertion.
REQ-004 mode1_run_i  input  1  level; request a full-image linear read.
REQ-005 fetch_run_i  input  1  level; request one 3-row window read (mode 2).
REQ-006 is_mode2_i  input  1  high while the system is in a mode-2 session.
REQ-007 cnt_len_i  input  20  number of pixels to read for the current request.
REQ-008 bram_en_o  output  1  BRAM read enable.
REQ-009 bram_addr_o  output  ADDR_W  BRAM read address.
REQ-010 bram_rdata_i  input  DATA_W  BRAM read data, valid exactly 1 cycle after bram_en_o.
REQ-011 out_valid_o  output  1  output pixel valid.
REQ-012 out_data_o  output  DATA_W  output pixel.
REQ-013 out_ready_i  input  1  sink accepts the pixel when out_valid_o and out_ready_i are both high.
REQ-014 mode1_done_o  output  1  one-cycle pulse; mode-1 read complete.
REQ-015 fetch_done_o  output  1  one-cycle pulse; window read complete.
REQ-016 cnt_img_row_o  output  10  start row of the current or most recent mode-2 window.

Function
REQ-017 FSM states: S_IDLE, S_READ, S_DRAIN, S_DONE; the state register is updated on the clk edge.
REQ-018 S_IDLE: if mode1_run_i, latch mode=1, len=cnt_len_i, base=0 and go to S_READ; else if fetch_run_i, latch mode=2, len=cnt_len_i, base=row*MAX_COL and go to S_READ.
REQ-019 If mode1_run_i and fetch_run_i are high together in S_IDLE, mode 1 SHALL win.
REQ-020 A latched len of 0 SHALL go from S_IDLE directly to S_DONE, with no BRAM reads.
REQ-021 S_READ: assert bram_en_o when issued<len and (fifo_count+inflight)<2, with bram_addr_o=base+issued; issued increments on each read issued.
REQ-022 inflight SHALL be 1 in the cycle after a read is issued, else 0; returning data is written into a 2-entry output FIFO.
REQ-023 The FIFO SHALL never overflow, never drop or duplicate a pixel, and keep pixels in address order.
REQ-024 out_valid_o SHALL be high whenever the FIFO is non-empty; out_data_o is the head entry; pop on valid&ready.
REQ-025 Simultaneous FIFO push and pop SHALL leave the count unchanged.
REQ-026 The FSM SHALL go S_READ to S_DRAIN in the cycle the last read (issued=len-1) is issued.
REQ-027 The FSM SHALL go S_DRAIN to S_DONE when the FIFO is empty and inflight=0.
REQ-028 S_DONE: pulse mode1_done_o (mode 1) or fetch_done_o (mode 2) for exactly one cycle, then go to S_IDLE.
REQ-029 Run inputs SHALL be ignored outside S_IDLE; deasserting a run input mid-operation SHALL NOT abort it.
REQ-030 Row tracking: the first fetch after is_mode2_i rises SHALL use row=0; each later fetch start SHALL increment row by 1.
REQ-031 Row SHALL saturate at MAX_ROW-3, with no wrap.
REQ-032 When is_mode2_i is low, row SHALL clear to 0 and the first-fetch flag SHALL rearm.
REQ-033 cnt_img_row_o SHALL equal row; base SHALL be formed by incrementally adding MAX_COL (no multiplier), at ADDR_W width.
REQ-034 Worst-case completion latency, with out_ready_i held high, SHALL be len+3 cycles from leaving S_IDLE to the done pulse.

Reset
REQ-035 When rst is asserted: state=S_IDLE; issued, inflight, FIFO count, row and len = 0; first-fetch flag armed.
REQ-036 During reset every output SHALL be 0: bram_en_o, bram_addr_o, out_valid_o, out_data_o, both done pulses and cnt_img_row_o.
REQ-037 Reset asserted mid-operation SHALL discard in-flight and buffered pixels and produce no done pulse.
REQ-038 After rst deasserts, the block SHALL start a request only when it sees a run input in S_IDLE.

Verification
REQ-039 mode1_run_i=1, cnt_len_i=291600, out_ready_i=1 -> addresses 0..291599 read in order; 291600 pixels out; one mode1_done_o pulse at or before 291603 cycles.
REQ-040 is_mode2_i=1; 538 fetches with cnt_len_i=1620 -> windows at row 0..537 and addresses row*540..row*540+1619; final cnt_img_row_o=537.
REQ-041 Fetch with out_ready_i toggling on a 1-cycle-on/3-cycles-off pattern -> 1620 pixels, no loss or duplication, FIFO count never exceeds 2, one fetch_done_o.
REQ-042 cnt_len_i=0 fetch -> bram_en_o never asserted; fetch_done_o pulses 2 cycles after fetch_run_i is sampled.
REQ-043 rst pulsed at pixel 700 of a fetch -> outputs 0 immediately, no done pulse; next fetch reads from row 0 address 0 after is_mode2_i toggles.
REQ-044 mode1_run_i and fetch_run_i both high in S_IDLE -> mode-1 read performed; only mode1_done_o pulses.

Source files
------------

// File: rtl/mem_seq.sv
// BRAM read sequencer: linear full-image reads (mode 1) or 3-row window reads (mode 2),
// streamed through a 2-entry output FIFO with a valid/ready handshake.
module mem_seq #(
  parameter int unsigned MAX_ROW = 540,
  parameter int unsigned MAX_COL = 540,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode1_run_i,
  input  logic              fetch_run_i,
  input  logic              is_mode2_i,
  input  logic [19:0]       cnt_len_i,
  output logic              bram_en_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  input  logic [DATA_W-1:0] bram_rdata_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic              mode1_done_o,
  output logic              fetch_done_o,
  output logic [9:0]        cnt_img_row_o
);

  localparam int unsigned LEN_W = 20;
  localparam int unsigned ROW_W = 10;
  localparam logic [ROW_W-1:0]  ROW_SAT  = ROW_W'(MAX_ROW - 3);
  localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(MAX_COL);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t              state_q;
  logic                mode2_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    issued_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   rowbase_q;
  logic [ROW_W-1:0]    row_q;
  logic                first_q;
  logic                inflight_q;
  logic [DATA_W-1:0]   fifo_q [2];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          count_q;
  logic                done1_q;
  logic                done2_q;

  logic                pop_d;
  logic [2:0]          occ_d;
  logic                issue_d;
  logic                last_d;
  logic                drained_d;
  logic [ROW_W-1:0]    row_d;
  logic [ADDR_W-1:0]   rowbase_d;

  // Occupancy counts the pop happening this cycle so a steady stream issues one read per cycle.
  always_comb begin
    pop_d     = (count_q != 2'd0) && out_ready_i;
    occ_d     = 3'(count_q) - 3'(pop_d) + 3'(inflight_q);
    issue_d   = (state_q == S_READ) && (issued_q < len_q) && (occ_d < 3'd2);
    last_d    = issue_d && (issued_q == len_q - LEN_W'(1));
    drained_d = !inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop_d));
  end

  // Window row for the next fetch; base advances by one row of pixels at a time.
  always_comb begin
    row_d     = '0;
    rowbase_d = '0;
    if (is_mode2_i && !first_q) begin
      if (row_q < ROW_SAT) begin
        row_d     = row_q + ROW_W'(1);
        rowbase_d = rowbase_q + COL_STEP;
      end else begin
        row_d     = row_q;
        rowbase_d = rowbase_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode2_q    <= 1'b0;
      len_q      <= '0;
      issued_q   <= '0;
      base_q     <= '0;
      rowbase_q  <= '0;
      row_q      <= '0;
      first_q    <= 1'b1;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      done1_q    <= 1'b0;
      done2_q    <= 1'b0;
    end else begin
      done1_q    <= 1'b0;
      done2_q    <= 1'b0;
      inflight_q <= issue_d;
      if (issue_d) issued_q <= issued_q + LEN_W'(1);

      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= bram_rdata_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_d) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(inflight_q) - 2'(pop_d);

      if (!is_mode2_i) begin
        row_q     <= '0;
        rowbase_q <= '0;
        first_q   <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (mode1_run_i) begin
            mode2_q  <= 1'b0;
            len_q    <= cnt_len_i;
            base_q   <= '0;
            issued_q <= '0;
            state_q  <= (cnt_len_i == '0) ? S_DONE : S_READ;
          end else if (fetch_run_i) begin
            mode2_q   <= 1'b1;
            len_q     <= cnt_len_i;
            base_q    <= rowbase_d;
            row_q     <= row_d;
            rowbase_q <= rowbase_d;
            first_q   <= !is_mode2_i;
            issued_q  <= '0;
            state_q   <= (cnt_len_i == '0) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          if (last_d) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drained_d) state_q <= S_DONE;
        end
        S_DONE: begin
          done1_q <= ~mode2_q;
          done2_q <= mode2_q;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bram_en_o     = issue_d;
  assign bram_addr_o   = issue_d ? (base_q + ADDR_W'(issued_q)) : '0;
  assign out_valid_o   = (count_q != 2'd0);
  assign out_data_o    = out_valid_o ? fifo_q[rd_ptr_q] : '0;
  assign mode1_done_o  = done1_q;
  assign fetch_done_o  = done2_q;
  assign cnt_img_row_o = row_q;

endmodule

// File: tb/tb_mem_seq.sv
// Randomized bench for mem_seq: BRAM model with random contents, expected address/pixel
// streams and window rows computed from the request (mode, row, length).
module tb_mem_seq;

  localparam int unsigned MAX_ROW = 8;
  localparam int unsigned MAX_COL = 12;
  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned DATA_W  = 8;
  localparam int LIMIT = 3000;

  logic              clk = 1'b0;
  logic              rst;
  logic              mode1_run_i, fetch_run_i, is_mode2_i, out_ready_i;
  logic [19:0]       cnt_len_i;
  logic              bram_en_o;
  logic [ADDR_W-1:0] bram_addr_o;
  logic [DATA_W-1:0] bram_rdata_i;
  logic              out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  logic              mode1_done_o, fetch_done_o;
  logic [9:0]        cnt_img_row_o;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] mem [256];
  int addr_log[$];
  int pix_log[$];
  int n_done1 = 0;
  int n_done2 = 0;

  mem_seq #(.MAX_ROW(MAX_ROW), .MAX_COL(MAX_COL), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .mode1_run_i(mode1_run_i), .fetch_run_i(fetch_run_i), .is_mode2_i(is_mode2_i),
    .cnt_len_i(cnt_len_i),
    .bram_en_o(bram_en_o), .bram_addr_o(bram_addr_o), .bram_rdata_i(bram_rdata_i),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
    .mode1_done_o(mode1_done_o), .fetch_done_o(fetch_done_o), .cnt_img_row_o(cnt_img_row_o)
  );

  always #5 clk = ~clk;

  // BRAM: data for the address presented with enable appears on the next cycle
  always @(posedge clk) if (bram_en_o) bram_rdata_i <= mem[bram_addr_o[7:0]];

  always @(negedge clk) begin
    if (bram_en_o) addr_log.push_back(int'(bram_addr_o));
    if (out_valid_o && out_ready_i) pix_log.push_back(int'(out_data_o));
    if (mode1_done_o) n_done1++;
    if (fetch_done_o) n_done2++;
  end

  function automatic logic ready_val(input int rmode, input int k);
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return 1'($urandom_range(0, 1));
    return (k % 4) == 0;
  endfunction

  // Drives one request for a single cycle, then waits (bounded) for a done pulse.
  task automatic do_request(input bit m1, input bit f, input int len, input int rmode,
                            output int lat, output int maxo, output bit to);
    int a0, p0, o;
    bit hit;
    a0 = addr_log.size(); p0 = pix_log.size();
    lat = 0; maxo = 0; hit = 1'b0;
    @(posedge clk); #1;
    mode1_run_i = m1; fetch_run_i = f; cnt_len_i = 20'(len); out_ready_i = ready_val(rmode, 0);
    for (int k = 1; k <= LIMIT && !hit; k++) begin
      @(posedge clk); #1;
      mode1_run_i = 1'b0; fetch_run_i = 1'b0; out_ready_i = ready_val(rmode, k);
      @(negedge clk); #1;
      o = (addr_log.size() - a0) - (pix_log.size() - p0);
      if (o > maxo) maxo = o;
      if (mode1_done_o || fetch_done_o) begin hit = 1'b1; lat = k; end
    end
    to = !hit;
    @(posedge clk); #1;
    out_ready_i = 1'b1;
  endtask

  // Index of first mismatch in the address and pixel streams against base..base+len-1, or -1.
  function automatic int first_bad_addr(input int a0, input int base, input int len);
    for (int i = 0; i < len; i++) if (addr_log[a0 + i] != base + i) return i;
    return -1;
  endfunction

  function automatic int first_bad_pix(input int p0, input int base, input int len);
    for (int i = 0; i < len; i++) if (pix_log[p0 + i] != int'(mem[8'(base + i)])) return i;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    mode1_run_i = 1'b0; fetch_run_i = 1'b0; is_mode2_i = 1'b0; out_ready_i = 1'b1; cnt_len_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (bram_en_o !== 1'b0) begin errors++; $display("FAIL rst_en got=%b want=0", bram_en_o); end
    vectors++; if (bram_addr_o !== '0) begin errors++; $display("FAIL rst_addr got=%0d want=0", bram_addr_o); end
    vectors++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", out_valid_o); end
    vectors++; if (out_data_o !== '0) begin errors++; $display("FAIL rst_data got=%0d want=0", out_data_o); end
    vectors++; if (mode1_done_o !== 1'b0) begin errors++; $display("FAIL rst_done1 got=%b want=0", mode1_done_o); end
    vectors++; if (fetch_done_o !== 1'b0) begin errors++; $display("FAIL rst_done2 got=%b want=0", fetch_done_o); end
    vectors++; if (cnt_img_row_o !== '0) begin errors++; $display("FAIL rst_row got=%0d want=0", cnt_img_row_o); end
    @(posedge clk); #1; rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vectors++; if (addr_log.size() != 0) begin errors++; $display("FAIL idle_no_read got=%0d want=0", addr_log.size()); end
  endtask

  task automatic check_stream(input string nm, input int a0, input int p0, input int base, input int len);
    int bad;
    vectors++;
    if (addr_log.size() - a0 != len) begin errors++; $display("FAIL %s_nreads got=%0d want=%0d", nm, addr_log.size() - a0, len); end
    else begin
      bad = first_bad_addr(a0, base, len);
      if (bad >= 0) begin errors++; $display("FAIL %s_addr idx=%0d got=%0d want=%0d", nm, bad, addr_log[a0 + bad], base + bad); end
    end
    vectors++;
    if (pix_log.size() - p0 != len) begin errors++; $display("FAIL %s_npix got=%0d want=%0d", nm, pix_log.size() - p0, len); end
    else begin
      bad = first_bad_pix(p0, base, len);
      if (bad >= 0) begin errors++; $display("FAIL %s_pix idx=%0d got=%0d want=%0d", nm, bad, pix_log[p0 + bad], mem[8'(base + bad)]); end
    end
  endtask

  task automatic test_mode1();
    int lens[3];
    int a0, p0, d1, d2, lat, maxo;
    bit to;
    lens[0] = int'(MAX_ROW * MAX_COL); lens[1] = 1; lens[2] = int'($urandom_range(2, 60));
    for (int t = 0; t < 3; t++) begin
      a0 = addr_log.size(); p0 = pix_log.size(); d1 = n_done1; d2 = n_done2;
      do_request(1'b1, 1'b0, lens[t], 0, lat, maxo, to);
      vectors++; if (to) begin errors++; $display("FAIL m1_timeout len=%0d got=none want=done", lens[t]); end
      check_stream("m1", a0, p0, 0, lens[t]);
      vectors++; if (lat > lens[t] + 4) begin errors++; $display("FAIL m1_latency got=%0d want<=%0d", lat, lens[t] + 4); end
      vectors++; if (n_done1 - d1 != 1 || n_done2 != d2) begin
        errors++; $display("FAIL m1_done got=%0d/%0d want=1/0", n_done1 - d1, n_done2 - d2); end
    end
  endtask

  task automatic test_fetch_rows();
    int a0, p0, d2, lat, maxo, row_m, len;
    bit to, first;
    len = int'(3 * MAX_COL);
    @(posedge clk); #1; is_mode2_i = 1'b0;
    repeat (2) @(posedge clk);
    #1; is_mode2_i = 1'b1;
    first = 1'b1; row_m = 0;
    for (int f = 0; f < int'(MAX_ROW); f++) begin
      if (first) row_m = 0;
      else if (row_m < int'(MAX_ROW) - 3) row_m = row_m + 1;
      first = 1'b0;
      a0 = addr_log.size(); p0 = pix_log.size(); d2 = n_done2;
      do_request(1'b0, 1'b1, len, 1, lat, maxo, to);
      vectors++; if (to) begin errors++; $display("FAIL fetch_timeout f=%0d got=none want=done", f); end
      vectors++; if (cnt_img_row_o !== 10'(row_m)) begin
        errors++; $display("FAIL fetch_row f=%0d got=%0d want=%0d", f, cnt_img_row_o, row_m); end
      check_stream("fetch", a0, p0, row_m * int'(MAX_COL), len);
      vectors++; if (n_done2 - d2 != 1) begin errors++; $display("FAIL fetch_done got=%0d want=1", n_done2 - d2); end
    end
  endtask

  task automatic test_backpressure();
    int a0, p0, d2, lat, maxo, len;
    bit to;
    len = int'(3 * MAX_COL);
    @(posedge clk); #1; is_mode2_i = 1'b0;
    @(posedge clk); #1; is_mode2_i = 1'b1;
    a0 = addr_log.size(); p0 = pix_log.size(); d2 = n_done2;
    do_request(1'b0, 1'b1, len, 2, lat, maxo, to);
    vectors++; if (to) begin errors++; $display("FAIL bp_timeout got=none want=done"); end
    check_stream("bp", a0, p0, 0, len);
    vectors++; if (maxo > 2) begin errors++; $display("FAIL bp_occupancy got=%0d want<=2", maxo); end
    vectors++; if (n_done2 - d2 != 1) begin errors++; $display("FAIL bp_done got=%0d want=1", n_done2 - d2); end
  endtask

  task automatic test_zero_len();
    int a0, d1, d2, lat, maxo;
    bit to;
    a0 = addr_log.size(); d1 = n_done1; d2 = n_done2;
    do_request(1'b0, 1'b1, 0, 0, lat, maxo, to);
    vectors++; if (addr_log.size() != a0) begin errors++; $display("FAIL zero_reads got=%0d want=0", addr_log.size() - a0); end
    vectors++; if (to || lat != 2) begin errors++; $display("FAIL zero_latency got=%0d want=2", lat); end
    vectors++; if (n_done2 - d2 != 1 || n_done1 != d1) begin
      errors++; $display("FAIL zero_done got=%0d/%0d want=0/1", n_done1 - d1, n_done2 - d2); end
  endtask

  task automatic test_mid_reset();
    int p0, a0, d1, d2, lat, maxo, k;
    bit to;
    p0 = pix_log.size(); d1 = n_done1; d2 = n_done2;
    @(posedge clk); #1;
    fetch_run_i = 1'b1; cnt_len_i = 20'(3 * MAX_COL); out_ready_i = 1'b1;
    @(posedge clk); #1; fetch_run_i = 1'b0;
    for (k = 0; k < 200 && (pix_log.size() - p0) < 10; k++) @(negedge clk);
    vectors++; if (pix_log.size() - p0 < 10) begin errors++; $display("FAIL mr_progress got=%0d want=10", pix_log.size() - p0); end
    @(posedge clk); #2; rst = 1'b1; #1;
    vectors++; if ({bram_en_o, out_valid_o, mode1_done_o, fetch_done_o} !== 4'b0 || bram_addr_o !== '0 ||
                   out_data_o !== '0 || cnt_img_row_o !== '0) begin
      errors++; $display("FAIL mr_outputs got=en%b v%b d%0d a%0d row%0d want=all0", bram_en_o, out_valid_o,
                         out_data_o, bram_addr_o, cnt_img_row_o); end
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    a0 = addr_log.size();
    repeat (40) @(posedge clk);
    #1;
    vectors++; if (n_done1 != d1 || n_done2 != d2) begin
      errors++; $display("FAIL mr_no_done got=%0d want=0", (n_done1 - d1) + (n_done2 - d2)); end
    vectors++; if (addr_log.size() != a0) begin errors++; $display("FAIL mr_idle got=%0d want=0", addr_log.size() - a0); end
    is_mode2_i = 1'b0;
    @(posedge clk); #1; is_mode2_i = 1'b1;
    a0 = addr_log.size(); p0 = pix_log.size();
    do_request(1'b0, 1'b1, int'(MAX_COL), 1, lat, maxo, to);
    vectors++; if (to) begin errors++; $display("FAIL mr_timeout got=none want=done"); end
    vectors++; if (cnt_img_row_o !== '0) begin errors++; $display("FAIL mr_row got=%0d want=0", cnt_img_row_o); end
    check_stream("mr", a0, p0, 0, int'(MAX_COL));
  endtask

  task automatic test_both_runs();
    int a0, p0, d1, d2, lat, maxo, len;
    bit to;
    len = int'($urandom_range(5, 40));
    a0 = addr_log.size(); p0 = pix_log.size(); d1 = n_done1; d2 = n_done2;
    do_request(1'b1, 1'b1, len, 1, lat, maxo, to);
    vectors++; if (to) begin errors++; $display("FAIL both_timeout got=none want=done"); end
    check_stream("both", a0, p0, 0, len);
    vectors++; if (n_done1 - d1 != 1 || n_done2 != d2) begin
      errors++; $display("FAIL both_done got=%0d/%0d want=1/0", n_done1 - d1, n_done2 - d2); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset();
    test_mode1();
    test_fetch_rows();
    test_backpressure();
    test_zero_len();
    test_both_runs();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
